// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the EX stage, owns the architectural HI/LO registers.
// Latency: mult/multu busy MULT_CYCLES, div/divu busy DIV_CYCLES, mthi/mtlo visible next cycle.
// Backpressure: Busy is asserted while an operation is in flight; Start during Busy is ignored.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  logic [0:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  // Result computed at issue and held until the busy window expires.
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        res_wr_q, res_wr_d;

  logic signed [63:0] smul;
  logic        [63:0] umul;
  logic               b_zero;
  logic               s_ovf;
  logic signed [31:0] sdivisor;
  logic signed [31:0] squo;
  logic signed [31:0] srem;
  logic        [31:0] udivisor;
  logic        [31:0] uquo;
  logic        [31:0] urem;

  // Single-cycle arithmetic on the live EX operands; only sampled at issue.
  always_comb begin
    smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    umul = {32'b0, A} * {32'b0, B};
    b_zero = (B == 32'h0);
    // Most-negative / -1 overflows a 32-bit signed divide; dividing by +1
    // instead yields exactly the required quotient 0x80000000 and remainder 0.
    s_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    sdivisor = (b_zero || s_ovf) ? 32'sd1 : $signed(B);
    squo = $signed(A) / sdivisor;
    srem = $signed(A) % sdivisor;
    udivisor = b_zero ? 32'd1 : B;
    uquo = A / udivisor;
    urem = A % udivisor;
  end

  // Next-state: issue from IDLE, count down in RUN, commit on the last busy cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (MDOp)
            OP_MULT: begin
              res_hi_d = smul[63:32];
              res_lo_d = smul[31:0];
              res_wr_d = 1'b1;
              cnt_d    = MULT_N;
              state_d  = S_RUN;
            end
            OP_MULTU: begin
              res_hi_d = umul[63:32];
              res_lo_d = umul[31:0];
              res_wr_d = 1'b1;
              cnt_d    = MULT_N;
              state_d  = S_RUN;
            end
            OP_DIV: begin
              res_hi_d = srem;
              res_lo_d = squo;
              // Divide by zero still occupies the unit but leaves HI/LO alone.
              res_wr_d = !b_zero;
              cnt_d    = DIV_N;
              state_d  = S_RUN;
            end
            OP_DIVU: begin
              res_hi_d = urem;
              res_lo_d = uquo;
              res_wr_d = !b_zero;
              cnt_d    = DIV_N;
              state_d  = S_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q <= 5'd1) begin
          if (res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
          res_wr_d = 1'b0;
          cnt_d    = 5'd0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
      res_hi_q <= 32'h0;
      res_lo_q <= 32'h0;
      res_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
    end
  end

  assign Busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed literal cases plus randomized traffic against a
// cycle-numbered behavioural model of HI/LO/Busy, compared every cycle.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = 3'b000;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int failures = 0;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An operation issued at edge number k occupies the unit until edge k+N,
  // where its result (if any) becomes architectural.
  int          cyc = 0;
  bit          m_ok = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  bit          m_active = 0;
  int          m_done = 0;
  bit          m_wr = 0;
  logic [31:0] p_hi = 0, p_lo = 0;
  int          overlap_starts = 0;

  always @(posedge clk) begin
    longint      sp, sa, sb, sq, sr;
    logic [63:0] up;
    bit          was_busy;
    cyc++;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_active = 0; m_ok = 1;
    end else begin
      was_busy = m_active;
      if (m_active && cyc == m_done) begin
        if (m_wr) begin m_hi = p_hi; m_lo = p_lo; end
        m_active = 0;
      end
      if (Start && was_busy) overlap_starts++;
      if (Start && !was_busy) begin
        sa = longint'($signed(A));
        sb = longint'($signed(B));
        case (MDOp)
          3'd1: begin
            sp = sa * sb;
            p_hi = sp[63:32]; p_lo = sp[31:0]; m_wr = 1;
            m_active = 1; m_done = cyc + MULT_N;
          end
          3'd2: begin
            up = {32'h0, A} * {32'h0, B};
            p_hi = up[63:32]; p_lo = up[31:0]; m_wr = 1;
            m_active = 1; m_done = cyc + MULT_N;
          end
          3'd3: begin
            m_wr = (B != 0);
            if (B != 0) begin
              sq = sa / sb; sr = sa % sb;
              p_hi = sr[31:0]; p_lo = sq[31:0];
            end
            m_active = 1; m_done = cyc + DIV_N;
          end
          3'd4: begin
            m_wr = (B != 0);
            if (B != 0) begin p_hi = A % B; p_lo = A / B; end
            m_active = 1; m_done = cyc + DIV_N;
          end
          3'd5: m_hi = A;
          3'd6: m_lo = A;
          default: ;
        endcase
      end
    end
  end

  // Compare process: outputs are meaningful every cycle after the first reset.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("cmp_busy", {31'b0, Busy}, {31'b0, m_active});
      chk("cmp_hi", HI, m_hi);
      chk("cmp_lo", LO, m_lo);
    end
  end

  // ---------------- stimulus helpers ----------------
  // All helpers start and end 1ns after a rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0; MDOp = 3'b000; A = $urandom; B = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!Busy) break;
      n++;
      if (i == 99) begin
        failures++;
        $display("FAIL wait_done timeout busy_cycles=%0d", n);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int roll;
    logic [2:0] op;
    logic [31:0] ra, rb;

    reset = 1'b1;
    step(3);
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    chk("reset_busy", {31'b0, Busy}, 32'h0);
    reset = 1'b0;
    step(2);

    issue(3'b001, 32'hFFFF_FFFF, 32'h2);
    wait_done(n);
    chk("mult_busy_cycles", n, MULT_N);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFE);

    issue(3'b010, 32'hFFFF_FFFF, 32'h2);
    wait_done(n);
    chk("multu_busy_cycles", n, MULT_N);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    issue(3'b011, 32'hFFFF_FFF9, 32'h2);
    wait_done(n);
    chk("div_busy_cycles", n, DIV_N);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    issue(3'b101, 32'h11, 32'h0);
    issue(3'b110, 32'h22, 32'h0);
    issue(3'b100, 32'h7, 32'h0);
    wait_done(n);
    chk("divu0_busy_cycles", n, DIV_N);
    chk("divu0_hi", HI, 32'h11);
    chk("divu0_lo", LO, 32'h22);

    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'h0);

    issue(3'b101, 32'h1234, 32'h0);
    chk("mthi_hi", HI, 32'h1234);
    chk("mthi_lo_kept", LO, 32'h8000_0000);
    chk("mthi_busy", {31'b0, Busy}, 32'h0);
    issue(3'b110, 32'h5678, 32'h0);
    chk("mtlo_lo", LO, 32'h5678);
    chk("mtlo_hi_kept", HI, 32'h1234);
    chk("mtlo_busy", {31'b0, Busy}, 32'h0);

    // A second Start while busy must be ignored and flagged.
    issue(3'b100, 32'd100, 32'd7);
    step(2);
    issue(3'b001, 32'h3, 32'h3);
    n = 0;
    wait_done(n);
    chk("overlap_flagged", overlap_starts, 1);
    chk("overlap_divu_hi", HI, 32'd2);
    chk("overlap_divu_lo", LO, 32'd14);

    // Reset in the third busy cycle of a divide discards the result.
    issue(3'b011, 32'd1000, 32'd3);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midreset_busy", {31'b0, Busy}, 32'h0);
    chk("midreset_hi", HI, 32'h0);
    chk("midreset_lo", LO, 32'h0);
    step(12);
    chk("midreset_nowrite_hi", HI, 32'h0);
    chk("midreset_nowrite_lo", LO, 32'h0);

    // Randomized traffic, issuing only when the unit is idle.
    for (int i = 0; i < 500; i++) begin
      if (Busy) begin
        step(1);
        continue;
      end
      roll = $urandom_range(0, 99);
      if (roll < 2) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        continue;
      end
      if (roll < 20) begin
        step(1);
        continue;
      end
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = 32'h0; end
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($signed($urandom_range(0, 200)) - 100);
                 rb = 32'($signed($urandom_range(0, 20)) - 10); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      issue(op, ra, rb);
    end
    step(DIV_N + 2);
    chk("no_random_overlap", overlap_starts, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit for the EX stage of the 5-stage pipeline.
- Consumes the forwarded EX operands (rs/rt after forwarding) of mult/multu/div/divu/mthi/mtlo and holds the architectural HI/LO registers.
- Its Busy output feeds the stall unit, which holds any MD-class instruction in ID while an operation is in flight.
- HI/LO are read combinationally by mfhi/mflo in EX.

Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (legal range 1..31)
- DIV_CYCLES, 10, Busy cycles for div/divu (legal range 1..31)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- Start  input  1  EX holds a valid MD-class instruction this cycle; 0 for bubbles and flushed slots
- MDOp  input  3  001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; other codes are no-op
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- Busy  output  1  an operation is in flight
- HI  output  32  current HI register
- LO  output  32  current LO register

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high: on a clk edge with reset=1, HI=0, LO=0, Busy=0, cycle counter=0 and FSM=IDLE. This applies mid-operation too; the pending result is discarded.
- FSM states: IDLE and RUN.
- IDLE -> RUN when Start=1 and MDOp is in {001..100}:
  - At that edge, latch A, B and MDOp.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Compute the result at that edge and hold it internally.
- RUN behaviour:
  - Busy=1.
  - The counter decrements each edge.
  - On the edge where the counter reaches 1, write HI/LO, set Busy=0 and return to IDLE.
  - With Start captured at edge k, Busy is high for cycles k+1 .. k+N, and new HI/LO are visible from the cycle Busy falls.
- Start/MDOp gating:
  - Start while Busy=1 is ignored. The stall unit guarantees this never happens; the bench flags it as an assertion.
  - Start with MDOp in {000,111}: no effect.
- mthi/mtlo (Start=1, MDOp 101/110, IDLE):
  - At that edge, HI<=A or LO<=A respectively.
  - Busy stays 0 and the other register is unchanged.
  - The new value is visible next cycle.
- Arithmetic:
  - mult: signed 32x32->64, {HI,LO}=A*B.
  - multu: the same, unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - div with A=0x80000000 and B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
- Divide by zero (B=0, div or divu):
  - Busy still runs for DIV_CYCLES.
  - HI/LO keep their prior values.
- Outputs HI/LO always reflect the committed registers, never partial results. mfhi during Busy is prevented by the stall unit.
- Implementation: a single-cycle combinational product/quotient with a delay counter is acceptable. A radix-2 iterative datapath is also acceptable if its results and Busy timing are identical to the above.

Test Plan:
- Reset then idle -> HI=0, LO=0, Busy=0. Assert reset in cycle 3 of a div -> next cycle Busy=0, HI=LO=0, and no later write.
- Start, mult, A=0xFFFFFFFF, B=2 -> Busy high exactly 5 cycles. When it falls, HI=0xFFFFFFFF, LO=0xFFFFFFFE; unchanged before that.
- multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div of A=0xFFFFFFF9 (-7) by B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu of 7 by 0 with prior HI=0x11, LO=0x22 -> Busy 10 cycles, then HI=0x11, LO=0x22.
  - div of 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0x1234 followed next cycle by mtlo A=0x5678 -> Busy never rises; HI=0x1234 then LO=0x5678, each visible one cycle after its Start.
- Start mult while Busy from a running divu -> the second Start is ignored and the assertion fires; divu results are committed on schedule.
